// File: rtl/exp_norm_scheduler_if.sv
// ---------------------------------------------------------------------------
// exp_norm_scheduler_if
//   Bundles the lane-exponent input stream and the group-result output
//   stream of exp_norm_scheduler.
//
//   Handshake: a beat transfers on the rising clock edge where valid and ready
//   are both high. A producer keeps valid and its payload stable until that
//   edge. ready may depend on state but never on the same-cycle valid.
//
//   Modports
//     master : environment side. Drives in_valid/in_exp/in_last and out_ready.
//              Receives in_ready and the result fields.
//     slave  : scheduler side. The directions are the reverse of master.
//
//   Signals
//     in_valid, in_ready, in_exp[expWidth], in_last   lane exponent stream
//     out_valid, out_ready, max_exp[expWidth],
//     exp_offset_num[4*expWidth], out_last            group result stream
//     blk_max_exp[expWidth]  present only when EXP_SCHED_BLOCK_MAX_EN is defined
// ---------------------------------------------------------------------------
interface exp_norm_scheduler_if #(
  parameter int expWidth = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [expWidth-1:0]   in_exp;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [expWidth-1:0]   max_exp;
  logic [4*expWidth-1:0] exp_offset_num;
  logic                  out_last;
`ifdef EXP_SCHED_BLOCK_MAX_EN
  logic [expWidth-1:0]   blk_max_exp;

  modport master (
    output in_valid, in_exp, in_last, out_ready,
    input  in_ready, out_valid, max_exp, exp_offset_num, out_last, blk_max_exp
  );

  modport slave (
    input  in_valid, in_exp, in_last, out_ready,
    output in_ready, out_valid, max_exp, exp_offset_num, out_last, blk_max_exp
  );
`else
  modport master (
    output in_valid, in_exp, in_last, out_ready,
    input  in_ready, out_valid, max_exp, exp_offset_num, out_last
  );

  modport slave (
    input  in_valid, in_exp, in_last, out_ready,
    output in_ready, out_valid, max_exp, exp_offset_num, out_last
  );
`endif
endinterface

// File: rtl/exp_norm_scheduler.sv
// ---------------------------------------------------------------------------
// exp_norm_scheduler
//   Sequences the 4-lane block-exponent normalizer. The module collects one
//   exponent per input handshake into a 4-lane group. It then computes the
//   group max and the per-lane offsets (max - lane). It presents the result
//   until the downstream accepts it. It counts groups per block and flags
//   the last group.
//
//   Parameters
//     expWidth  exponent width (unsigned)
//     GROUPS    groups per block (>= 1)
//
//   Ports
//     clk          clock. All state changes on the rising edge.
//     rst          asynchronous reset, active-high
//     bus          exp_norm_scheduler_if.slave. Carries both the lane and
//                  result streams.
//     dbg_state    current FSM state (0 FILL, 1 CALC, 2 HOLD)
//     dbg_grp_cnt  group index within the current block
//
//   Optional feature (macro EXP_SCHED_BLOCK_MAX_EN)
//     Adds bus.blk_max_exp, the running max of max_exp over the block. It is
//     updated in CALC and is final while out_valid && out_last. It is cleared
//     after the out_last handshake.
//
//   Flow: FILL (accept lanes) -> CALC (one cycle) -> HOLD (present result)
//   -> FILL. Groups never overlap. in_ready is low outside FILL and
//   out_ready is ignored outside HOLD.
// ---------------------------------------------------------------------------
module exp_norm_scheduler #(
  parameter int expWidth = 3,
  parameter int GROUPS   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  exp_norm_scheduler_if.slave    bus,
  output logic [1:0]             dbg_state,
  output logic [((GROUPS > 1) ? $clog2(GROUPS) : 1)-1:0] dbg_grp_cnt
);

  localparam int CNT_W = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int OFF_W = 4 * expWidth;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_CALC = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [expWidth-1:0] lane_q [4];
  logic [1:0]          lane_cnt;
  logic [CNT_W-1:0]    grp_cnt;
  logic                last_q;      // in_last seen on the closing lane

  logic [expWidth-1:0] max_q;
  logic [OFF_W-1:0]    off_q;
  logic                out_last_q;

  logic                in_xfer;
  logic                out_xfer;
  logic                close_grp;
  logic                grp_end;
  logic [expWidth-1:0] calc_max;
  logic [OFF_W-1:0]    calc_off;

  // ---------------------------------------------------------------------
  // Handshake decode
  // ---------------------------------------------------------------------
  // in_ready is gated by rst directly. This keeps it low during the whole
  // reset pulse, not only after the state register clears.
  assign bus.in_ready  = (state == S_FILL) && !rst;
  assign bus.out_valid = (state == S_HOLD);

  assign in_xfer   = bus.in_valid && bus.in_ready;
  assign out_xfer  = bus.out_valid && bus.out_ready;
  assign close_grp = in_xfer && ((lane_cnt == 2'd3) || bus.in_last);
  assign grp_end   = (grp_cnt == CNT_W'(GROUPS - 1));

  // ---------------------------------------------------------------------
  // Normalization datapath
  // ---------------------------------------------------------------------
  // Lanes that the group did not fill hold 0. They are cleared after every
  // output handshake and on reset, so no padding logic is needed here.
  always_comb begin
    calc_max = lane_q[0];
    calc_off = '0;
    for (int i = 1; i < 4; i++) begin
      if (lane_q[i] > calc_max) begin
        calc_max = lane_q[i];
      end
    end
    // calc_max >= every lane, so each difference fits in expWidth bits.
    for (int i = 0; i < 4; i++) begin
      calc_off[i*expWidth +: expWidth] = calc_max - lane_q[i];
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FILL: begin
        if (close_grp) begin
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          state_nxt = S_FILL;
        end
      end
      default: begin
        state_nxt = S_FILL;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Lane capture, group counting and result registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        lane_q[i] <= '0;
      end
      lane_cnt   <= '0;
      grp_cnt    <= '0;
      last_q     <= 1'b0;
      max_q      <= '0;
      off_q      <= '0;
      out_last_q <= 1'b0;
    end else begin
      if (in_xfer) begin
        lane_q[lane_cnt] <= bus.in_exp;
        lane_cnt         <= lane_cnt + 2'd1;
        last_q           <= bus.in_last;
      end

      if (state == S_CALC) begin
        max_q      <= calc_max;
        off_q      <= calc_off;
        out_last_q <= last_q || grp_end;
      end

      if (out_xfer) begin
        for (int i = 0; i < 4; i++) begin
          lane_q[i] <= '0;
        end
        lane_cnt <= '0;
        last_q   <= 1'b0;
        grp_cnt  <= out_last_q ? '0 : grp_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.max_exp        = max_q;
  assign bus.exp_offset_num = off_q;
  assign bus.out_last       = out_last_q;

`ifdef EXP_SCHED_BLOCK_MAX_EN
  // ---------------------------------------------------------------------
  // Running block max. It folds in each group's max as that group is
  // computed, so it already includes the last group when out_last is shown.
  // ---------------------------------------------------------------------
  logic [expWidth-1:0] blk_max_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_max_q <= '0;
    end else if (state == S_CALC) begin
      blk_max_q <= (calc_max > blk_max_q) ? calc_max : blk_max_q;
    end else if (out_xfer && out_last_q) begin
      blk_max_q <= '0;
    end
  end

  assign bus.blk_max_exp = blk_max_q;
`endif

  assign dbg_state   = state;
  assign dbg_grp_cnt = grp_cnt;

endmodule

// File: tb/tb_exp_norm_scheduler.sv
// ---------------------------------------------------------------------------
// tb_exp_norm_scheduler
//   Self-checking bench for exp_norm_scheduler with expWidth=3, GROUPS=8.
//   A vector table drives whole groups. Expected results are queued at drive
//   time and popped when the DUT completes an output handshake. Hand-written
//   sequences cover latency, back-pressure hold and mid-group reset.
// ---------------------------------------------------------------------------
module tb_exp_norm_scheduler;

  localparam int W   = 3;
  localparam int G   = 8;
  localparam int EW  = 1 + W + 4 * W;   // {out_last, max_exp, offsets}
  localparam int NV  = 10;

  typedef struct {
    logic [3:0][W-1:0] lanes;            // lanes[0] is the first lane sent
    int                n;
    bit                last;
    logic [W-1:0]      emax;
    logic [4*W-1:0]    eoff;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] dbg_state;
  logic [2:0] dbg_grp_cnt;

  always #5 clk = ~clk;

  exp_norm_scheduler_if #(.expWidth(W)) bus ();

  exp_norm_scheduler #(.expWidth(W), .GROUPS(G)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .dbg_state   (dbg_state),
    .dbg_grp_cnt (dbg_grp_cnt)
  );

  // ------------------------------------------------------------------
  // Scoreboard state
  // ------------------------------------------------------------------
  logic [EW-1:0] exp_q [$];
  int            n_checks = 0;
  int            n_pass   = 0;
  int            m_grp    = 0;      // model group index within block
  logic [W-1:0]  blk_run  = '0;     // model running block max
  vec_t          v [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference normalizer. Lanes beyond n count as 0.
  function automatic logic [W+4*W-1:0] ref_calc(input logic [3:0][W-1:0] lanes, input int n);
    logic [W-1:0]   mx;
    logic [W-1:0]   val;
    logic [4*W-1:0] off;
    mx  = '0;
    off = '0;
    for (int i = 0; i < n; i++) begin
      if (lanes[i] > mx) mx = lanes[i];
    end
    for (int i = 0; i < 4; i++) begin
      val = (i < n) ? lanes[i] : '0;
      off[i*W +: W] = mx - val;
    end
    return {mx, off};
  endfunction

  task automatic push_expected(input bit last, input logic [W-1:0] emax, input logic [4*W-1:0] eoff);
    bit elast;
    elast = last || (m_grp == G - 1);
    m_grp = elast ? 0 : m_grp + 1;
    exp_q.push_back({elast, emax, eoff});
  endtask

  // Sends n lanes. Call at a negedge. Returns at the negedge after the last
  // transfer edge.
  task automatic send_lanes(input logic [3:0][W-1:0] lanes, input int n, input bit last);
    int t;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_exp   = lanes[i];
      bus.in_last  = last && (i == n - 1);
      t = 0;
      while (!bus.in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) begin
        check("in_ready_timeout", 32'd0, 32'd1);
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) check("drain_timeout", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    @(negedge clk);
  endtask

  // ------------------------------------------------------------------
  // Output monitor: compares each accepted result to the queue head
  // ------------------------------------------------------------------
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("max_exp",        32'(bus.max_exp),        32'(e[4*W +: W]));
        check("exp_offset_num", 32'(bus.exp_offset_num), 32'(e[4*W-1:0]));
        check("out_last",       32'(bus.out_last),       32'(e[EW-1]));
`ifdef EXP_SCHED_BLOCK_MAX_EN
        if (e[4*W +: W] > blk_run) blk_run = e[4*W +: W];
        if (e[EW-1]) begin
          check("blk_max_exp", 32'(bus.blk_max_exp), 32'(blk_run));
          blk_run = '0;
        end
`endif
      end
    end
  end

  // Global time limit
  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ------------------------------------------------------------------
  // Main sequence
  // ------------------------------------------------------------------
  initial begin
    logic [W+4*W-1:0] r;
    logic [3:0][W-1:0] lanes;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_exp    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    // Vector table: two fixed groups followed by eight random full groups.
    v[0].lanes = {3'd2, 3'd3, 3'd5, 3'd1}; v[0].n = 4; v[0].last = 1'b0;
    v[0].emax  = 3'd5; v[0].eoff = 12'h684;
    v[1].lanes = {3'd0, 3'd0, 3'd2, 3'd7}; v[1].n = 2; v[1].last = 1'b1;
    v[1].emax  = 3'd7; v[1].eoff = 12'hFE8;
    for (int k = 2; k < NV; k++) begin
      for (int j = 0; j < 4; j++) v[k].lanes[j] = 3'($urandom_range(0, 7));
      v[k].n    = 4;
      v[k].last = 1'b0;
      r         = ref_calc(v[k].lanes, 4);
      v[k].emax = r[4*W +: W];
      v[k].eoff = r[4*W-1:0];
    end

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),       32'd0);
    check("rst_out_valid", 32'(bus.out_valid),      32'd0);
    check("rst_max_exp",   32'(bus.max_exp),        32'd0);
    check("rst_offsets",   32'(bus.exp_offset_num), 32'd0);
    check("rst_out_last",  32'(bus.out_last),       32'd0);
    check("rst_grp_cnt",   32'(dbg_grp_cnt),        32'd0);
    check("rst_state",     32'(dbg_state),          32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Table-driven groups. The 8 random ones form a full block after the
    // early-closed group resets the count.
    for (int k = 0; k < NV; k++) begin
      push_expected(v[k].last, v[k].emax, v[k].eoff);
      send_lanes(v[k].lanes, v[k].n, v[k].last);
      if (k == 0) begin
        // One edge after the final transfer the result is still being computed.
        check("lat_calc_out_valid", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("lat_hold_out_valid", 32'(bus.out_valid), 32'd1);
      end
      if (k == 1) begin
        wait_drain();
        check("grp_cnt_after_in_last", 32'(dbg_grp_cnt), 32'd0);
      end
    end
    wait_drain();

    // Back-pressure: the result holds for 5 cycles. Junk input is ignored.
    bus.out_ready = 1'b0;
    lanes = {3'd4, 3'd4, 3'd4, 3'd4};
    push_expected(1'b0, 3'd4, 12'h000);
    send_lanes(lanes, 4, 1'b0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_exp   = 3'd7;
    for (int c = 0; c < 5; c++) begin
      check("hold_out_valid", 32'(bus.out_valid),      32'd1);
      check("hold_max_exp",   32'(bus.max_exp),        32'd4);
      check("hold_offsets",   32'(bus.exp_offset_num), 32'h000);
      check("hold_in_ready",  32'(bus.in_ready),       32'd0);
      @(negedge clk);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain();

    // Reset after two lanes discards the partial group and clears grp_cnt.
    lanes = {3'd0, 3'd0, 3'd5, 3'd3};
    send_lanes(lanes, 2, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_grp_cnt",   32'(dbg_grp_cnt),   32'd0);
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst_in_ready",  32'(bus.in_ready),  32'd0);
    rst     = 1'b0;
    m_grp   = 0;
    blk_run = '0;
    @(negedge clk);
    lanes = {3'd6, 3'd0, 3'd0, 3'd0};
    r = ref_calc(lanes, 4);
    push_expected(1'b0, r[4*W +: W], r[4*W-1:0]);
    send_lanes(lanes, 4, 1'b0);
    wait_drain();

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
